// File: rtl/data_mem_ctrl.sv
// Data-memory slave: single outstanding request, fixed response latency.
// Optional out-of-range checking is enabled with `define DMEM_ERR_CHECK_EN.
module data_mem_ctrl #(
  parameter int addr_width_p = 10,
  parameter int lat_p        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_wen_i,
  input  logic        req_byte_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_yumi_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  input  logic        resp_yumi_i,
  output logic        err_o
);

  localparam int Depth = 1 << addr_width_p;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]  r_cnt;
  logic        r_resp_valid;
  logic [31:0] r_data;
  logic [31:0] r_mem [Depth];

  logic [addr_width_p-1:0] w_idx;
  logic [1:0]  w_lane;
  logic        w_accept;
  logic        w_done;
  logic        w_oor;
  logic        w_we;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [31:0] w_rdata;

  assign w_idx  = req_addr_i[addr_width_p+1:2];
  assign w_lane = req_addr_i[1:0];

`ifdef DMEM_ERR_CHECK_EN
  logic r_err;

  assign w_oor = |req_addr_i[31:addr_width_p+2];
  assign err_o = r_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_accept && w_oor) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused;

  // Upper address bits alias onto the array.
  assign w_unused = ^req_addr_i[31:addr_width_p+2];
  assign w_oor    = 1'b0;
  assign err_o    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (req_valid_i) begin
          w_next = (lat_p > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd1) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (w_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_yumi_o = 1'b0;
    if (r_state == IDLE) begin
      req_yumi_o = req_valid_i;
    end
  end

  assign w_accept     = req_yumi_o;
  assign w_done       = r_resp_valid && resp_yumi_i;
  assign resp_valid_o = r_resp_valid;
  assign resp_data_o  = r_data;

  assign w_word  = r_mem[w_idx];
  assign w_byte  = w_word[8*w_lane +: 8];
  assign w_rdata = req_byte_i ? {24'b0, w_byte} : w_word;
  assign w_we    = w_accept && req_wen_i && !w_oor && reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt        <= 4'd0;
      r_resp_valid <= 1'b0;
      r_data       <= 32'd0;
    end else begin
      if (w_accept) begin
        r_cnt <= 4'(lat_p - 1);
        if (req_wen_i) begin
          r_data <= 32'd0;
        end else if (w_oor) begin
          r_data <= 32'hDEAD_BEEF;
        end else begin
          r_data <= w_rdata;
        end
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Valid lags RESP entry by one edge; this completes the lat_p count.
      r_resp_valid <= (r_state == RESP) && !w_done;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      if (req_byte_i) begin
        r_mem[w_idx][8*w_lane +: 8] <= req_wdata_i[7:0];
      end else begin
        r_mem[w_idx] <= req_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (lat_p=2 main instance, lat_p=1 side instance).
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        r_valid, r_wen, r_byte, r_yumi;
  logic [31:0] r_addr, r_wdata;
  logic        w_req_yumi, w_resp_valid, w_err;
  logic [31:0] w_resp_data;

  logic        q_valid, q_wen, q_byte, q_yumi;
  logic [31:0] q_addr, q_wdata;
  logic        u1_req_yumi, u1_resp_valid, u1_err;
  logic [31:0] u1_resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.addr_width_p(10), .lat_p(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(r_valid), .req_wen_i(r_wen), .req_byte_i(r_byte),
    .req_addr_i(r_addr), .req_wdata_i(r_wdata),
    .req_yumi_o(w_req_yumi), .resp_valid_o(w_resp_valid),
    .resp_data_o(w_resp_data), .resp_yumi_i(r_yumi), .err_o(w_err)
  );

  data_mem_ctrl #(.addr_width_p(10), .lat_p(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid_i(q_valid), .req_wen_i(q_wen), .req_byte_i(q_byte),
    .req_addr_i(q_addr), .req_wdata_i(q_wdata),
    .req_yumi_o(u1_req_yumi), .resp_valid_o(u1_resp_valid),
    .resp_data_o(u1_resp_data), .resp_yumi_i(q_yumi), .err_o(u1_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!w_resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 32'd2);
  endtask

  task automatic xact(input string tag, input logic wen, input logic byt,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp);
    r_valid = 1'b1; r_wen = wen; r_byte = byt;
    r_addr = addr; r_wdata = wdata;
    #1;
    chk({tag, "_acc"}, 32'(w_req_yumi), 32'd1);
    @(posedge clk); #1;
    r_valid = 1'b0;
    wait_valid(tag);
    chk({tag, "_data"}, w_resp_data, exp);
    r_yumi = 1'b1;
    @(posedge clk); #1;
    r_yumi = 1'b0;
    chk({tag, "_drop"}, 32'(w_resp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    r_valid = 0; r_wen = 0; r_byte = 0; r_yumi = 0;
    r_addr = 0; r_wdata = 0;
    q_valid = 0; q_wen = 0; q_byte = 0; q_yumi = 0;
    q_addr = 0; q_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(w_resp_valid), 32'd0);
    chk("rst_data", w_resp_data, 32'd0);
    chk("rst_err", 32'(w_err), 32'd0);
    chk("rst_yumi", 32'(w_req_yumi), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    xact("st_w10", 1'b1, 1'b0, 32'h10, 32'h1234_5678, 32'd0);
    xact("ld_w10", 1'b0, 1'b0, 32'h10, 32'd0, 32'h1234_5678);
    xact("st_b11", 1'b1, 1'b1, 32'h11, 32'hFFFF_FFAB, 32'd0);
    xact("ld_w10b", 1'b0, 1'b0, 32'h10, 32'd0, 32'h1234_AB78);
    xact("ld_b13", 1'b0, 1'b1, 32'h13, 32'd0, 32'h0000_0012);
    xact("ld_b11", 1'b0, 1'b1, 32'h11, 32'd0, 32'h0000_00AB);
    xact("ld_w12", 1'b0, 1'b0, 32'h12, 32'd0, 32'h1234_AB78);
    xact("st_w00", 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 32'd0);
    xact("ld_w00", 1'b0, 1'b0, 32'h0, 32'd0, 32'hCAFE_F00D);

`ifdef DMEM_ERR_CHECK_EN
    xact("ld_oor", 1'b0, 1'b0, 32'h1000, 32'd0, 32'hDEAD_BEEF);
    chk("err_set", 32'(w_err), 32'd1);
    xact("ld_after", 1'b0, 1'b0, 32'h10, 32'd0, 32'h1234_AB78);
    chk("err_sticky", 32'(w_err), 32'd1);
`else
    xact("ld_alias", 1'b0, 1'b0, 32'h1000, 32'd0, 32'hCAFE_F00D);
    chk("err_tied", 32'(w_err), 32'd0);
`endif

    // Stall RESP for 5 cycles with a pending request behind it.
    r_valid = 1'b1; r_wen = 1'b0; r_byte = 1'b0; r_addr = 32'h10;
    @(posedge clk); #1;
    r_addr = 32'h0;
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(w_resp_valid), 32'd1);
      chk("stall_data", w_resp_data, 32'h1234_AB78);
      chk("stall_noacc", 32'(w_req_yumi), 32'd0);
      @(posedge clk); #1;
    end
    r_yumi = 1'b1;
    #1;
    chk("yumi_noacc", 32'(w_req_yumi), 32'd0);
    @(posedge clk); #1;
    r_yumi = 1'b0;
    chk("post_drop", 32'(w_resp_valid), 32'd0);
    chk("post_acc", 32'(w_req_yumi), 32'd1);
    @(posedge clk); #1;
    r_valid = 1'b0;
    wait_valid("pend");
    chk("pend_data", w_resp_data, 32'hCAFE_F00D);
    r_yumi = 1'b1;
    @(posedge clk); #1;
    r_yumi = 1'b0;

    // Reset while BUSY aborts the load.
    r_valid = 1'b1; r_addr = 32'h10;
    @(posedge clk); #1;
    r_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("rb_valid0", 32'(w_resp_valid), 32'd0);
    chk("rb_err", 32'(w_err), 32'd0);
    @(posedge clk); #1;
    chk("rb_valid1", 32'(w_resp_valid), 32'd0);
    xact("rb_ld", 1'b0, 1'b0, 32'h10, 32'd0, 32'h1234_AB78);

    // lat_p=1: one store then back-to-back loads, immediate yumi.
    q_valid = 1'b1; q_wen = 1'b1; q_addr = 32'h20;
    q_wdata = 32'h55AA_33CC; q_yumi = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      chk("l1_yumi", 32'(u1_req_yumi), 32'((i % 3) == 0));
      chk("l1_valid", 32'(u1_resp_valid), 32'((i % 3) == 2));
      if ((i % 3) == 2) begin
        chk("l1_data", u1_resp_data, (i == 2) ? 32'd0 : 32'h55AA_33CC);
      end
      if (i == 1) q_wen = 1'b0;
      @(posedge clk); #1;
    end
    q_valid = 1'b0;
    q_yumi = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
